envelope_gen: RTL

Per-channel ADSR envelope generator for the sound core. One instance per tone channel feeds the 4-bit envelope inputs of the channel mixer, which multiplies it with channel volume. Driven by a note gate and four 4-bit rate/level settings. Produces a registered 4-bit amplitude stepping through attack, decay, sustain and release.

---
 rtl/envelope_gen.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/envelope_gen.sv
// Per-channel ADSR envelope: a 4-bit amplitude that steps through attack, decay,
// sustain and release, paced by a shared base tick and per-phase rate counters.
module envelope_gen #(
    parameter int TICK_DIV = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gate,
    input  logic [3:0] attack,
    input  logic [3:0] decay,
    input  logic [3:0] sustain,
    input  logic [3:0] release_rate,
    output logic [3:0] env,
    output logic [2:0] state,
    output logic       active
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    env_q, env_d;
    logic [3:0]    rc_q, rc_d;
    logic [PW-1:0] ps_q, ps_d;
    logic          gate_q, gate_d;
    logic          active_q, active_d;

    logic          base_tick;
    logic          rise;
    logic          step;
    logic [3:0]    rate;

    always_comb begin
        base_tick = (ps_q == PS_LAST);
        ps_d      = base_tick ? '0 : ps_q + 1'b1;
        gate_d    = gate;
        rise      = gate && !gate_q;

        case (state_q)
            ST_ATTACK:  rate = attack;
            ST_DECAY:   rate = decay;
            default:    rate = release_rate;
        endcase
        // >= rather than == so a rate lowered mid-phase fires on the next tick
        step = base_tick && (rc_q >= rate);

        state_d = state_q;
        env_d   = env_q;
        rc_d    = rc_q;

        if (rise) begin
            state_d = ST_ATTACK;
            rc_d    = '0;
        end else if (!gate && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                               state_q == ST_SUSTAIN)) begin
            state_d = ST_RELEASE;
            rc_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    env_d = '0;
                    rc_d  = '0;
                end
                ST_ATTACK: begin
                    if (step) begin
                        rc_d = '0;
                        if (env_q == 4'd15) begin
                            state_d = ST_DECAY;
                        end else begin
                            env_d = env_q + 4'd1;
                            if (env_q == 4'd14) state_d = ST_DECAY;
                        end
                    end else if (base_tick) begin
                        rc_d = rc_q + 4'd1;
                    end
                end
                ST_DECAY: begin
                    if (step) begin
                        rc_d = '0;
                        if (env_q <= sustain) begin
                            state_d = ST_SUSTAIN;
                        end else begin
                            env_d = env_q - 4'd1;
                            if (env_q - 4'd1 == sustain) state_d = ST_SUSTAIN;
                        end
                    end else if (base_tick) begin
                        rc_d = rc_q + 4'd1;
                    end
                end
                ST_SUSTAIN: begin
                    env_d = sustain;
                    rc_d  = '0;
                end
                ST_RELEASE: begin
                    if (step) begin
                        rc_d = '0;
                        if (env_q == 4'd0) begin
                            state_d = ST_IDLE;
                        end else begin
                            env_d = env_q - 4'd1;
                            if (env_q == 4'd1) state_d = ST_IDLE;
                        end
                    end else if (base_tick) begin
                        rc_d = rc_q + 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    env_d   = '0;
                    rc_d    = '0;
                end
            endcase
        end

        active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            env_q    <= '0;
            rc_q     <= '0;
            ps_q     <= '0;
            gate_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            env_q    <= env_d;
            rc_q     <= rc_d;
            ps_q     <= ps_d;
            gate_q   <= gate_d;
            active_q <= active_d;
        end
    end

    assign env    = env_q;
    assign state  = state_q;
    assign active = active_q;
endmodule
